// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low glyph constants ({g,f,e,d,c,b,a})
// and the decode-result struct. The hex-to-segment encoder uses the same table.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       is_hex;
    logic       is_blank;
    logic [3:0] nibble;
  } seg_decode_t;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Display-bus bundle for the scan decoder: the multiplexed segment/anode lines
// coming in and the reassembled value and status pulses going out.
interface seven_seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_valid;
  logic                    pattern_err;
  logic [2:0]              err_digit;

  // Display-side driver (or bench) that owns the segment/anode lines.
  modport master (
    output seg_in, an_in,
    input  value_out, digit_valid, frame_valid, pattern_err, err_digit
  );

  // Decoder side.
  modport slave (
    input  seg_in, an_in,
    output value_out, digit_valid, frame_valid, pattern_err, err_digit
  );
endinterface

// File: rtl/seven_seg_pattern_decoder.sv
// Combinational inverse of the hex-to-segment encoder: maps a 7-bit active-low
// pattern to {is_hex, is_blank, nibble}. Anything else decodes as neither.
module seven_seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0]  pattern_i,
  output seg_decode_t result_o
);

  // Glyph lookup; unknown patterns fall through to the all-zero result.
  always_comb begin
    result_o = '{is_hex: 1'b0, is_blank: 1'b0, nibble: 4'h0};
    case (pattern_i)
      SEG_0:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h0};
      SEG_1:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h1};
      SEG_2:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h2};
      SEG_3:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h3};
      SEG_4:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h4};
      SEG_5:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h5};
      SEG_6:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h6};
      SEG_7:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h7};
      SEG_8:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h8};
      SEG_9:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'h9};
      SEG_A:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'hA};
      SEG_B:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'hB};
      SEG_C:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'hC};
      SEG_D:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'hD};
      SEG_E:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'hE};
      SEG_F:     result_o = '{is_hex: 1'b1, is_blank: 1'b0, nibble: 4'hF};
      SEG_BLANK: result_o = '{is_hex: 1'b0, is_blank: 1'b1, nibble: 4'h0};
      default:   result_o = '{is_hex: 1'b0, is_blank: 1'b0, nibble: 4'h0};
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Loopback monitor for a multiplexed active-low seven-segment display: decodes
// each scan slot back to a hex nibble and reassembles the displayed value.
// Optional build macro SEVEN_SEG_STABILITY_FILTER_EN: when defined, a digit is
// committed only after STABLE_CYCLES identical samples (rejects anode ghosting);
// when undefined, every change of (digit, pattern) commits immediately.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                     clk,
  input logic                     rst,
  seven_seg_scan_decoder_if.slave bus
);

  // Registered input sample; idle state is "no anode, all segments off".
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  // Previous valid sample, used to detect a continuing run.
  logic                  prev_ok_q;
  logic [2:0]            prev_idx_q;
  logic [6:0]            prev_seg_q;

  logic                  sample_ok_s;
  logic [2:0]            idx_s;
  logic                  same_s;
  logic                  commit_s;
  seg_decode_t           dec_s;

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;
  logic [2:0]              err_digit_q, err_digit_d;

  // Capture the raw display lines once so everything downstream sees one sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= bus.seg_in;
      an_q  <= bus.an_in;
    end
  end

  // Slot qualification: exactly one active (low) anode selects the digit.
  always_comb begin
    sample_ok_s = ($countones(~an_q) == 1);
    idx_s       = 3'd0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!an_q[d]) begin
        idx_s = 3'(d);
      end else begin
        idx_s = idx_s;
      end
    end
    same_s = prev_ok_q && (prev_idx_q == idx_s) && (prev_seg_q == seg_q);
  end

  // Remember the last valid sample; an invalid slot breaks the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ok_q  <= 1'b0;
      prev_idx_q <= 3'd0;
      prev_seg_q <= SEG_BLANK;
    end else if (sample_ok_s) begin
      prev_ok_q  <= 1'b1;
      prev_idx_q <= idx_s;
      prev_seg_q <= seg_q;
    end else begin
      prev_ok_q  <= 1'b0;
    end
  end

`ifdef SEVEN_SEG_STABILITY_FILTER_EN
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

  logic [RUN_W-1:0] run_q, run_d;

  // Run counter: load 1 on a new pattern, count up on repeats, saturate.
  always_comb begin
    run_d = run_q;
    if (!sample_ok_s) begin
      run_d = '0;
    end else if (!same_s) begin
      run_d = RUN_W'(1);
    end else if (run_q == RUN_W'(STABLE_CYCLES)) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_W'(1);
    end
    // Commit exactly on the transition into STABLE_CYCLES.
    commit_s = sample_ok_s && same_s && (run_q == RUN_W'(STABLE_CYCLES - 1));
  end

  // Run counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`else
  // Unfiltered: any new (digit, pattern) commits on its first sample.
  always_comb begin
    commit_s = sample_ok_s && !same_s;
  end
`endif

  seven_seg_pattern_decoder u_pattern_decoder (
    .pattern_i (seg_q),
    .result_o  (dec_s)
  );

  // Commit handling and frame tracking; seen is cleared the cycle after it
  // fills, and a commit in that same cycle lands after the clear.
  always_comb begin
    value_d       = value_q;
    digit_valid_d = digit_valid_q;
    seen_d        = (&seen_q) ? '0 : seen_q;
    frame_d       = &seen_q;
    err_d         = commit_s && !dec_s.is_hex && !dec_s.is_blank;
    err_digit_d   = err_d ? idx_s : err_digit_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (commit_s && (idx_s == 3'(d)) && dec_s.is_hex) begin
        value_d[4*d +: 4] = dec_s.nibble;
        digit_valid_d[d]  = 1'b1;
        seen_d[d]         = 1'b1;
      end else if (commit_s && (idx_s == 3'(d)) && dec_s.is_blank) begin
        digit_valid_d[d]  = 1'b0;
        seen_d[d]         = 1'b1;
      end else begin
        digit_valid_d[d]  = digit_valid_d[d];
      end
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q       <= '0;
      digit_valid_q <= '0;
      seen_q        <= '0;
      frame_q       <= 1'b0;
      err_q         <= 1'b0;
      err_digit_q   <= 3'd0;
    end else begin
      value_q       <= value_d;
      digit_valid_q <= digit_valid_d;
      seen_q        <= seen_d;
      frame_q       <= frame_d;
      err_q         <= err_d;
      err_digit_q   <= err_digit_d;
    end
  end

  assign bus.value_out   = value_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.pattern_err = err_q;
  assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Commit latency follows the SEVEN_SEG_STABILITY_FILTER_EN build setting.
module tb_seven_seg_scan_decoder;
  import seven_seg_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;
`ifdef SEVEN_SEG_STABILITY_FILTER_EN
  localparam int LAT = SC + 1;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   n_frame;
  int   n_err;

  seven_seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one-cycle pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.frame_valid) n_frame++;
    if (bus.pattern_err) n_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    bus.an_in  = an;
    bus.seg_in = seg;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; n_frame = 0; n_err = 0;
    rst = 1'b1;
    drive(4'b1111, SEG_BLANK);
    tick(2);

    // Reset state
    chk("rst_value", 32'(bus.value_out), 32'h0);
    chk("rst_dvalid", 32'(bus.digit_valid), 32'h0);
    chk("rst_frame", 32'(bus.frame_valid), 32'h0);
    chk("rst_perr", 32'(bus.pattern_err), 32'h0);
    chk("rst_errdig", 32'(bus.err_digit), 32'h0);
    rst = 1'b0;

    // Single digit latency: digit 0 shows "3"
    drive(4'b1110, SEG_3);
    tick(LAT - 1);
    chk("lat_early_dv", 32'(bus.digit_valid), 32'h0);
    chk("lat_early_val", 32'(bus.value_out), 32'h0);
    tick(1);
    chk("lat_val", 32'(bus.value_out), 32'h0003);
    chk("lat_dv", 32'(bus.digit_valid), 32'h1);

    // Glitches between slots
`ifdef SEVEN_SEG_STABILITY_FILTER_EN
    drive(4'b1101, SEG_6); tick(SC - 1);
    drive(4'b1100, SEG_6); tick(2);
    drive(4'b1101, SEG_6); tick(SC - 1);
    drive(4'b1111, SEG_6); tick(2);
    drive(4'b1101, SEG_6); tick(SC - 1);
    drive(4'b1111, SEG_BLANK); tick(3);
`else
    drive(4'b1100, SEG_6); tick(2);
    drive(4'b1111, SEG_6); tick(2);
`endif
    chk("glitch_dv", 32'(bus.digit_valid), 32'h1);
    chk("glitch_val", 32'(bus.value_out), 32'h0003);
    chk("glitch_err", 32'(n_err), 32'd0);

    // Full scan 1,2,A,F
    drive(4'b1110, SEG_1); tick(5);
    chk("scan0_dv", 32'(bus.digit_valid), 32'h1);
    drive(4'b1101, SEG_2); tick(5);
    drive(4'b1011, SEG_A); tick(5);
    chk("scan2_frame_cnt", 32'(n_frame), 32'd0);
    drive(4'b0111, SEG_F); tick(LAT);
    chk("scan_val", 32'(bus.value_out), 32'hFA21);
    chk("scan_dv", 32'(bus.digit_valid), 32'hF);
    chk("scan_frame_at_commit", 32'(bus.frame_valid), 32'h0);
    tick(1);
    chk("scan_frame_pulse", 32'(bus.frame_valid), 32'h1);
    tick(1);
    chk("scan_frame_end", 32'(bus.frame_valid), 32'h0);
    chk("scan_frame_cnt", 32'(n_frame), 32'd1);

    // Illegal pattern on digit 2
    drive(4'b1011, 7'b1010101);
    tick(LAT - 1);
    chk("perr_early", 32'(bus.pattern_err), 32'h0);
    tick(1);
    chk("perr_pulse", 32'(bus.pattern_err), 32'h1);
    chk("perr_digit", 32'(bus.err_digit), 32'd2);
    chk("perr_val", 32'(bus.value_out), 32'hFA21);
    chk("perr_dv", 32'(bus.digit_valid), 32'hF);
    tick(3);
    chk("perr_end", 32'(bus.pattern_err), 32'h0);
    chk("perr_cnt", 32'(n_err), 32'd1);
    chk("perr_digit_hold", 32'(bus.err_digit), 32'd2);

    // Blank on digit 1, then complete a frame with 8,5,C
    drive(4'b1101, SEG_BLANK); tick(LAT);
    chk("blank_dv", 32'(bus.digit_valid), 32'hD);
    chk("blank_val", 32'(bus.value_out), 32'hFA21);
    drive(4'b1110, SEG_8); tick(LAT);
    drive(4'b1011, SEG_5); tick(LAT);
    drive(4'b0111, SEG_C); tick(LAT);
    chk("frame2_val", 32'(bus.value_out), 32'hC528);
    chk("frame2_at_commit", 32'(bus.frame_valid), 32'h0);
    tick(1);
    chk("frame2_pulse", 32'(bus.frame_valid), 32'h1);
    chk("frame2_dv", 32'(bus.digit_valid), 32'hD);

    // Reset mid-run
    drive(4'b1110, SEG_9); tick(2);
    rst = 1'b1;
    #1;
    chk("mrst_val", 32'(bus.value_out), 32'h0);
    chk("mrst_dv", 32'(bus.digit_valid), 32'h0);
    chk("mrst_frame", 32'(bus.frame_valid), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(LAT - 1);
    chk("mrst_early_dv", 32'(bus.digit_valid), 32'h0);
    tick(1);
    chk("mrst_val_after", 32'(bus.value_out), 32'h0009);
    chk("mrst_dv_after", 32'(bus.digit_valid), 32'h1);

`ifdef SEVEN_SEG_STABILITY_FILTER_EN
    // Short run never commits
    drive(4'b1101, SEG_4); tick(SC - 1);
    drive(4'b1111, SEG_BLANK); tick(4);
    chk("short_dv", 32'(bus.digit_valid), 32'h1);
    chk("short_val", 32'(bus.value_out), 32'h0009);
`endif

    tick(2);
    chk("final_frame_cnt", 32'(n_frame), 32'd2);
    chk("final_err_cnt", 32'(n_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
